// File: rtl/execute_stage_pkg.sv
// Shared definitions for the execute stage: control widths, control-bit
// positions, ALU operation codes and the multiplier state encoding.
package execute_stage_pkg;

    localparam int NB_CONTROL_EX    = 5;
    localparam int NB_CONTROL_MA_WB = 7;

    // Bit positions inside the EX control word
    localparam int CTRL_ALU_SRC_IMM = 0;
    localparam int CTRL_ALU_OP_LSB  = 1;
    localparam int CTRL_ALU_OP_MSB  = 4;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11,
        ALU_MUL  = 4'd12
    } alu_op_e;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/mul_shift_add.sv
// Iterative shift-add multiplier: one partial-product step per cycle,
// low NB_DATA bits of the product, operands captured at start.
module mul_shift_add #(
    parameter int NB_DATA = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [NB_DATA-1:0] op_a,
    input  logic [NB_DATA-1:0] op_b,
    output logic               busy,
    output logic               done,
    output logic [NB_DATA-1:0] product
);
    import execute_stage_pkg::*;

    localparam int NB_COUNT = $clog2(NB_DATA);

    mul_state_e          state;
    mul_state_e          state_next;
    logic [NB_COUNT-1:0] count;
    logic [NB_DATA-1:0]  multiplicand;
    logic [NB_DATA-1:0]  multiplier;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= MUL_IDLE;
        else     state <= state_next;
    end

    // Next-state: start only from IDLE, so DONE can never re-trigger
    always_comb begin
        state_next = state;
        case (state)
            MUL_IDLE: if (start) state_next = MUL_BUSY;
            MUL_BUSY: if (count == NB_COUNT'(NB_DATA - 1)) state_next = MUL_DONE;
            MUL_DONE: state_next = MUL_IDLE;
            default:  state_next = MUL_IDLE;
        endcase
    end

    // Operand capture and shift-add iteration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count        <= '0;
            multiplicand <= '0;
            multiplier   <= '0;
            product      <= '0;
        end else begin
            case (state)
                MUL_IDLE: begin
                    if (start) begin
                        multiplicand <= op_a;
                        multiplier   <= op_b;
                        product      <= '0;
                        count        <= '0;
                    end
                end
                MUL_BUSY: begin
                    if (multiplier[0]) product <= product + multiplicand;
                    multiplicand <= multiplicand << 1;
                    multiplier   <= multiplier >> 1;
                    count        <= count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == MUL_BUSY);
    assign done = (state == MUL_DONE);

endmodule

// File: rtl/execute_stage.sv
// Pipeline execute stage: operand forwarding from MA/WB, single-cycle ALU,
// iterative multiplier with stall, and the EX/MA pipeline register.
module execute_stage #(
    parameter int NB_DATA           = 32,
    parameter int NB_ADDR_REGISTERS = 5,
    parameter int NB_CONTROL_EX     = execute_stage_pkg::NB_CONTROL_EX,
    parameter int NB_CONTROL_MA_WB  = execute_stage_pkg::NB_CONTROL_MA_WB
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic [NB_DATA-1:0]           i_rs_data,
    input  logic [NB_DATA-1:0]           i_rt_data,
    input  logic [NB_DATA-1:0]           i_imm,
    input  logic [NB_ADDR_REGISTERS-1:0] i_rs_num,
    input  logic [NB_ADDR_REGISTERS-1:0] i_rt_num,
    input  logic [NB_ADDR_REGISTERS-1:0] i_rd_num,
    input  logic [NB_CONTROL_EX-1:0]     i_control_ex,
    input  logic [NB_CONTROL_MA_WB-1:0]  i_control_ma_wb,
    input  logic [NB_ADDR_REGISTERS-1:0] i_ma_rd_num,
    input  logic                         i_ma_reg_write,
    input  logic [NB_DATA-1:0]           i_ma_rd_data,
    input  logic [NB_ADDR_REGISTERS-1:0] i_wb_rd_num,
    input  logic                         i_wb_reg_write,
    input  logic [NB_DATA-1:0]           i_wb_rd_data,
    output logic [NB_CONTROL_MA_WB-1:0]  o_control_ma_wb,
    output logic [NB_DATA-1:0]           o_mem_addr,
    output logic [NB_DATA-1:0]           o_mem_data,
    output logic [NB_ADDR_REGISTERS-1:0] o_rd_num,
    output logic                         o_stall
);
    import execute_stage_pkg::*;

    localparam int NB_SHAMT = $clog2(NB_DATA);

    alu_op_e              alu_op;
    logic                 alu_src_imm;
    logic [NB_DATA-1:0]   operand_a;
    logic [NB_DATA-1:0]   rt_forwarded;
    logic [NB_DATA-1:0]   operand_b;
    logic [NB_DATA-1:0]   alu_result;
    logic [NB_SHAMT-1:0]  shamt;
    logic                 mul_busy;
    logic                 mul_done;
    logic [NB_DATA-1:0]   mul_product;
    logic                 is_mul;

    assign alu_op      = alu_op_e'(i_control_ex[CTRL_ALU_OP_MSB:CTRL_ALU_OP_LSB]);
    assign alu_src_imm = i_control_ex[CTRL_ALU_SRC_IMM];
    assign is_mul      = (alu_op == ALU_MUL);

    // Forwarding: MA has priority over WB, r0 never forwards
    always_comb begin
        operand_a = i_rs_data;
        if (i_ma_reg_write && (i_ma_rd_num == i_rs_num) && (i_rs_num != '0))
            operand_a = i_ma_rd_data;
        else if (i_wb_reg_write && (i_wb_rd_num == i_rs_num) && (i_rs_num != '0))
            operand_a = i_wb_rd_data;

        rt_forwarded = i_rt_data;
        if (i_ma_reg_write && (i_ma_rd_num == i_rt_num) && (i_rt_num != '0))
            rt_forwarded = i_ma_rd_data;
        else if (i_wb_reg_write && (i_wb_rd_num == i_rt_num) && (i_rt_num != '0))
            rt_forwarded = i_wb_rd_data;

        operand_b = alu_src_imm ? i_imm : rt_forwarded;
    end

    assign shamt = operand_b[NB_SHAMT-1:0];

    // Single-cycle ALU; MUL result comes from the multiplier instead
    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_ADD:  alu_result = operand_a + operand_b;
            ALU_SUB:  alu_result = operand_a - operand_b;
            ALU_AND:  alu_result = operand_a & operand_b;
            ALU_OR:   alu_result = operand_a | operand_b;
            ALU_XOR:  alu_result = operand_a ^ operand_b;
            ALU_NOR:  alu_result = ~(operand_a | operand_b);
            ALU_SLT:  alu_result = NB_DATA'($signed(operand_a) < $signed(operand_b));
            ALU_SLTU: alu_result = NB_DATA'(operand_a < operand_b);
            ALU_SLL:  alu_result = operand_a << shamt;
            ALU_SRL:  alu_result = operand_a >> shamt;
            ALU_SRA:  alu_result = $unsigned($signed(operand_a) >>> shamt);
            ALU_LUI:  alu_result = operand_b << 16;
            default:  alu_result = '0;
        endcase
    end

    mul_shift_add #(
        .NB_DATA(NB_DATA)
    ) u_mul (
        .clk     (i_clk),
        .rst     (i_reset),
        .start   (is_mul),
        .op_a    (operand_a),
        .op_b    (operand_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // Stall while a MUL is being launched or iterating; released on DONE
    assign o_stall = mul_busy | (is_mul & ~mul_busy & ~mul_done);

    // EX/MA pipeline register; a stalled cycle inserts a bubble
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_control_ma_wb <= '0;
            o_mem_addr      <= '0;
            o_mem_data      <= '0;
            o_rd_num        <= '0;
        end else if (o_stall) begin
            o_control_ma_wb <= '0;
        end else begin
            o_control_ma_wb <= i_control_ma_wb;
            o_mem_addr      <= mul_done ? mul_product : alu_result;
            o_mem_data      <= rt_forwarded;
            o_rd_num        <= i_rd_num;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_execute_stage;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_rs_data, i_rt_data, i_imm;
    logic [4:0]  i_rs_num, i_rt_num, i_rd_num;
    logic [4:0]  i_control_ex;
    logic [6:0]  i_control_ma_wb;
    logic [4:0]  i_ma_rd_num;
    logic        i_ma_reg_write;
    logic [31:0] i_ma_rd_data;
    logic [4:0]  i_wb_rd_num;
    logic        i_wb_reg_write;
    logic [31:0] i_wb_rd_data;
    logic [6:0]  o_control_ma_wb;
    logic [31:0] o_mem_addr, o_mem_data;
    logic [4:0]  o_rd_num;
    logic        o_stall;

    execute_stage dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_rs_data       (i_rs_data),
        .i_rt_data       (i_rt_data),
        .i_imm           (i_imm),
        .i_rs_num        (i_rs_num),
        .i_rt_num        (i_rt_num),
        .i_rd_num        (i_rd_num),
        .i_control_ex    (i_control_ex),
        .i_control_ma_wb (i_control_ma_wb),
        .i_ma_rd_num     (i_ma_rd_num),
        .i_ma_reg_write  (i_ma_reg_write),
        .i_ma_rd_data    (i_ma_rd_data),
        .i_wb_rd_num     (i_wb_rd_num),
        .i_wb_reg_write  (i_wb_reg_write),
        .i_wb_rd_data    (i_wb_rd_data),
        .o_control_ma_wb (o_control_ma_wb),
        .o_mem_addr      (o_mem_addr),
        .o_mem_data      (o_mem_data),
        .o_rd_num        (o_rd_num),
        .o_stall         (o_stall)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Behavioural model state
    logic [6:0]  exp_ctrl = '0;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_data = '0;
    logic [4:0]  exp_rd   = '0;
    bit          exp_full = 1'b1;
    bit          mul_active = 1'b0;
    int          mul_age = 0;
    logic [31:0] mul_result = '0;
    logic [31:0] m_a, m_rt, m_b;
    int          m_op;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] num, input logic [31:0] rf);
        if (num != 5'd0 && i_ma_reg_write && i_ma_rd_num == num) return i_ma_rd_data;
        if (num != 5'd0 && i_wb_reg_write && i_wb_rd_num == num) return i_wb_rd_data;
        return rf;
    endfunction

    function automatic logic [31:0] alu(input int op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ext;
        ext = {{32{a[31]}}, a} >> b[4:0];
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return a & b;
            3:  return a | b;
            4:  return a ^ b;
            5:  return ~(a | b);
            6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            7:  return (a < b) ? 32'd1 : 32'd0;
            8:  return a << b[4:0];
            9:  return a >> b[4:0];
            10: return ext[31:0];
            11: return {b[15:0], 16'h0000};
            12: return a * b;
            default: return 32'd0;
        endcase
    endfunction

    // A MUL holds EX for 33 stalled cycles, then one result cycle
    function automatic bit model_stall();
        if (mul_active) return (mul_age < 33);
        return (i_control_ex[4:1] == 4'd12);
    endfunction

    // Model: expected pipeline-register contents after each edge
    always @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            exp_ctrl = '0; exp_addr = '0; exp_data = '0; exp_rd = '0;
            exp_full = 1'b1; mul_active = 1'b0; mul_age = 0;
        end else begin
            m_a  = fwd(i_rs_num, i_rs_data);
            m_rt = fwd(i_rt_num, i_rt_data);
            m_b  = i_control_ex[0] ? i_imm : m_rt;
            m_op = int'(i_control_ex[4:1]);
            if (mul_active) begin
                if (mul_age < 33) begin
                    mul_age++;
                    exp_ctrl = '0; exp_full = 1'b0;
                end else begin
                    exp_ctrl = i_control_ma_wb; exp_addr = mul_result;
                    exp_data = m_rt; exp_rd = i_rd_num; exp_full = 1'b1;
                    mul_active = 1'b0;
                end
            end else if (m_op == 12) begin
                mul_active = 1'b1; mul_age = 1;
                mul_result = alu(12, m_a, m_b);
                exp_ctrl = '0; exp_full = 1'b0;
            end else begin
                exp_ctrl = i_control_ma_wb; exp_addr = alu(m_op, m_a, m_b);
                exp_data = m_rt; exp_rd = i_rd_num; exp_full = 1'b1;
            end
        end
    end

    // Compare process: every cycle, away from the active edge
    always @(negedge i_clk) begin
        if (cmp_en) begin
            chk("stall", 32'(o_stall), 32'(model_stall()));
            chk("control", 32'(o_control_ma_wb), 32'(exp_ctrl));
            if (exp_full) begin
                chk("mem_addr", o_mem_addr, exp_addr);
                chk("mem_data", o_mem_data, exp_data);
                chk("rd_num", 32'(o_rd_num), 32'(exp_rd));
            end
        end
    end

    task automatic next_edge();
        @(posedge i_clk);
        #2;
    endtask

    task automatic clear_fwd();
        i_ma_rd_num = '0; i_ma_reg_write = 1'b0; i_ma_rd_data = '0;
        i_wb_rd_num = '0; i_wb_reg_write = 1'b0; i_wb_rd_data = '0;
    endtask

    task automatic set_instr(input logic [3:0] op, input logic imm_sel,
                             input logic [4:0] rs, input logic [31:0] rsd,
                             input logic [4:0] rt, input logic [31:0] rtd,
                             input logic [31:0] imm, input logic [4:0] rd,
                             input logic [6:0] ctl);
        i_control_ex = {op, imm_sel};
        i_rs_num = rs; i_rs_data = rsd;
        i_rt_num = rt; i_rt_data = rtd;
        i_imm = imm; i_rd_num = rd; i_control_ma_wb = ctl;
    endtask

    task automatic rand_fwd();
        i_ma_rd_num = 5'($urandom_range(0, 7)); i_ma_reg_write = 1'($urandom);
        i_ma_rd_data = $urandom;
        i_wb_rd_num = 5'($urandom_range(0, 7)); i_wb_reg_write = 1'($urandom);
        i_wb_rd_data = $urandom;
    endtask

    task automatic rand_instr();
        logic [3:0] op;
        op = ($urandom_range(0, 15) < 2) ? 4'd12 : 4'($urandom_range(0, 15));
        set_instr(op, 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), $urandom, $urandom,
                  5'($urandom), 7'($urandom));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1);
    end

    initial begin
        int n;
        int bub;
        i_reset = 1'b1;
        set_instr(4'd0, 1'b0, 5'd0, '0, 5'd0, '0, '0, 5'd0, 7'd0);
        clear_fwd();
        repeat (2) next_edge();
        cmp_en = 1'b1;
        chk("reset_ctrl", 32'(o_control_ma_wb), 32'd0);
        chk("reset_addr", o_mem_addr, 32'd0);
        chk("reset_data", o_mem_data, 32'd0);
        chk("reset_rd", 32'(o_rd_num), 32'd0);
        i_reset = 1'b0;

        // ADD 5+7, no forwarding
        set_instr(4'd0, 1'b0, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 5'd9, 7'h5A);
        next_edge();
        chk("add_addr", o_mem_addr, 32'd12);
        chk("add_ctrl", 32'(o_control_ma_wb), 32'h5A);
        chk("add_rd", 32'(o_rd_num), 32'd9);
        chk("add_data", o_mem_data, 32'd7);

        // MA wins over WB on the same register
        i_ma_rd_num = 5'd3; i_ma_reg_write = 1'b1; i_ma_rd_data = 32'hAA;
        i_wb_rd_num = 5'd3; i_wb_reg_write = 1'b1; i_wb_rd_data = 32'hBB;
        set_instr(4'd0, 1'b0, 5'd3, 32'h11, 5'd0, 32'd0, 32'd0, 5'd4, 7'h01);
        next_edge();
        chk("ma_fwd", o_mem_addr, 32'hAA);

        // WB writing r0 is not forwarded
        clear_fwd();
        i_wb_rd_num = 5'd0; i_wb_reg_write = 1'b1; i_wb_rd_data = 32'hFF;
        set_instr(4'd3, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd5, 7'h02);
        next_edge();
        chk("r0_fwd", o_mem_addr, 32'd0);
        clear_fwd();

        set_instr(4'd10, 1'b1, 5'd1, 32'h80000000, 5'd0, 32'd0, 32'd4, 5'd6, 7'h03);
        next_edge();
        chk("sra", o_mem_addr, 32'hF8000000);
        set_instr(4'd7, 1'b0, 5'd1, 32'd1, 5'd2, 32'hFFFFFFFF, 32'd0, 5'd7, 7'h04);
        next_edge();
        chk("sltu", o_mem_addr, 32'd1);
        set_instr(4'd6, 1'b0, 5'd1, 32'd1, 5'd2, 32'hFFFFFFFF, 32'd0, 5'd7, 7'h04);
        next_edge();
        chk("slt", o_mem_addr, 32'd0);

        // MUL 0xFFFFFFFF * 3; MA bus retargets rs mid-multiply
        set_instr(4'd12, 1'b0, 5'd4, 32'hFFFFFFFF, 5'd5, 32'd3, 32'd0, 5'd8, 7'h7F);
        #1;
        n = 0; bub = 0;
        while (o_stall === 1'b1 && n < 100) begin
            next_edge();
            n++;
            if (o_control_ma_wb == 7'd0) bub++;
            if (n == 5) begin
                i_ma_rd_num = 5'd4; i_ma_reg_write = 1'b1; i_ma_rd_data = 32'd0;
            end
        end
        chk("mul_stall_cycles", 32'(n), 32'd33);
        chk("mul_bubbles", 32'(bub), 32'd33);
        next_edge();
        chk("mul_result", o_mem_addr, 32'hFFFFFFFD);
        chk("mul_ctrl", 32'(o_control_ma_wb), 32'h7F);
        clear_fwd();

        // Reset in the middle of a multiply, then ADD 1+1
        set_instr(4'd12, 1'b0, 5'd1, 32'd7, 5'd2, 32'd9, 32'd0, 5'd3, 7'h33);
        repeat (11) next_edge();
        #1;
        i_reset = 1'b1;
        set_instr(4'd0, 1'b0, 5'd1, 32'd1, 5'd2, 32'd1, 32'd0, 5'd2, 7'h11);
        #1;
        chk("rst_busy_ctrl", 32'(o_control_ma_wb), 32'd0);
        chk("rst_busy_addr", o_mem_addr, 32'd0);
        chk("rst_busy_data", o_mem_data, 32'd0);
        chk("rst_busy_rd", 32'(o_rd_num), 32'd0);
        chk("rst_busy_stall", 32'(o_stall), 32'd0);
        #3;
        i_reset = 1'b0;
        next_edge();
        chk("post_rst_add", o_mem_addr, 32'd2);
        chk("post_rst_ctrl", 32'(o_control_ma_wb), 32'h11);

        // Randomized traffic; instruction inputs held while a MUL is in flight
        for (int i = 0; i < 3000; i++) begin
            if (!mul_active) rand_instr();
            rand_fwd();
            next_edge();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 Parameters SHALL be:
- NB_DATA, 32, datapath width.
- NB_ADDR_REGISTERS, 5, register-number width.
- NB_CONTROL_EX, 5, EX control width: [4:1] alu_op, [0] alu_src_imm.
- NB_CONTROL_MA_WB, 7, MA+WB control passed downstream.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- i_clk, in, 1, single clock, rising edge.
- i_reset, in, 1, reset; asynchronous, active-high.
- i_rs_data, i_rt_data, in, NB_DATA, register-file operands from ID.
- i_imm, in, NB_DATA, sign-extended immediate.
- i_rs_num, i_rt_num, i_rd_num, in, NB_ADDR_REGISTERS, source and destination numbers.
- i_control_ex, in, NB_CONTROL_EX, ALU control.
- i_control_ma_wb, in, NB_CONTROL_MA_WB, forwarded untouched when not bubbling.
- i_ma_rd_num, in, 5, i_ma_reg_write, in, 1, i_ma_rd_data, in, 32: unregistered MA-stage forwarding source.
- i_wb_rd_num, in, 5, i_wb_reg_write, in, 1, i_wb_rd_data, in, 32: WB-stage forwarding source.
- o_control_ma_wb, out, 7, registered control to MA.
- o_mem_addr, out, 32, registered ALU result.
- o_mem_data, out, 32, registered forwarded rt (store data).
- o_rd_num, out, 5, registered destination.
- o_stall, out, 1, combinational; holds IF/ID/EX inputs stable.

Function
REQ-003 Forwarding SHALL apply per operand (rs→A, rt→B_reg), in this priority:
- MA match: reg_write=1 and rd_num==src and src!=0.
- Otherwise WB match, same rule.
- Otherwise the register-file value.

REQ-004 Operand B SHALL be i_imm when alu_src_imm=1, else forwarded rt; o_mem_data SHALL always be forwarded rt.

REQ-005 alu_op SHALL select, on 32-bit wrap-around arithmetic:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
- 6 SLT (signed), 7 SLTU (result 0 or 1).
- 8 SLL, 9 SRL, 10 SRA: A shifted by B[4:0].
- 11 LUI: B<<16.
- 12 MUL: low 32 bits of A×B.
- 13–15 → result 0.

REQ-006 Non-MUL ops SHALL have 1-cycle latency: the result is registered on the edge after the inputs are presented.

REQ-007 Multiplier FSM states SHALL be IDLE, BUSY, DONE:
- IDLE→BUSY when alu_op==12: latch forwarded A and B, count=0.
- BUSY: one shift-add iteration per cycle; →DONE after 32 iterations.
- DONE→IDLE unconditionally.

REQ-008 o_stall SHALL be 1 in (IDLE and alu_op==12) and in BUSY, else 0; a MUL therefore occupies EX for 34 cycles.

REQ-009 Product register SHALL be loaded into o_mem_addr, together with rd_num and control, on the DONE cycle edge.

REQ-010 While o_stall=1 the output register SHALL load a bubble: o_control_ma_wb=0; other outputs don't-care.

REQ-011 Operands SHALL be latched at MUL start, so later changes on the MA/WB forwarding buses have no effect on the product.

REQ-012 A MUL immediately following a MUL SHALL start a new IDLE→BUSY sequence; DONE never re-triggers on the same instruction.

REQ-013 Forwarding from WB writing r0 SHALL be ignored; a simultaneous MA and WB match SHALL take MA data.

Reset
REQ-014 On i_reset assertion, asynchronously and independent of i_clk:
- o_control_ma_wb=0, o_mem_addr=0, o_mem_data=0, o_rd_num=0.
- FSM=IDLE, count=0.

REQ-015 Reset during BUSY SHALL abort the multiply; after release, the stage SHALL accept new input on the first edge.

Structure
REQ-016 Shared package SHALL hold the alu_op codes, the NB_CONTROL_* widths and the control-bit positions.

REQ-017 The iterative multiplier SHALL be sub-module mul_shift_add, with ports start, operands, busy, done and product.

Verification
REQ-018 Directed scenarios:
- ADD: rs=5, rt=7, no forwarding → o_mem_addr=12 one cycle later, control passed.
- MA forward: MA rd=3, reg_write=1, data=0xAA; WB rd=3, data=0xBB; rs=3 → A=0xAA.
- r0: WB rd=0, reg_write=1, data=0xFF; rs=0 with rf value 0 → A=0.
- MUL: A=0xFFFFFFFF, B=3 → o_stall high 33 cycles, 33 bubbles (control=0), then o_mem_addr=0xFFFFFFFD.
- Reset at BUSY cycle 10 → outputs 0 immediately, FSM IDLE; next ADD 1+1 → 2.
- SRA: A=0x80000000, B=4 → 0xF8000000; SLTU 1<0xFFFFFFFF → 1, SLT → 0.
